// File: rtl/gshare_branch_predictor_if.sv
// Predict/update bus of the gshare branch predictor.
// The master side (fetch/execute) issues requests; the slave side is the predictor.
interface gshare_branch_predictor_if #(
    parameter int I = 8,
    parameter int M = 2
);
    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic          upd_valid;
    logic [I-1:0]  upd_index;
    logic          upd_taken;
    logic          ready;
    logic          pred_out_valid;
    logic          pred_taken;
    logic [I-1:0]  pred_index;
    logic [M-1:0]  ghr;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_index, upd_taken,
        input  ready, pred_out_valid, pred_taken, pred_index, ghr
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_index, upd_taken,
        output ready, pred_out_valid, pred_taken, pred_index, ghr
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Correlating / gshare branch predictor: 2^(R+M) saturating counters indexed
// by PC bits combined with a non-speculative global history register.
// After reset the table is swept to weakly-not-taken before requests are taken.
module gshare_branch_predictor #(
    parameter int R        = 6,
    parameter int M        = 2,
    parameter int N        = 2,
    parameter int XOR_HASH = 0
) (
    input  logic clk,
    input  logic reset,
    gshare_branch_predictor_if.slave bus
);
    localparam int I     = R + M;
    localparam int DEPTH = 1 << I;
    localparam logic [N-1:0] WNT  = {1'b0, {(N-1){1'b1}}};
    localparam logic [I-1:0] LAST = {I{1'b1}};

    typedef enum logic {INIT, RUN} state_t;

    state_t         state_q, state_d;
    logic [I-1:0]   cnt_q, cnt_d;
    logic [M-1:0]   ghr_q, ghr_d;
    logic           ready_q, ready_d;
    logic           pov_q, pov_d;
    logic           taken_q, taken_d;
    logic [I-1:0]   pidx_q, pidx_d;
    logic [N-1:0]   table_q [DEPTH];

    logic           wr_en;
    logic [I-1:0]   wr_addr;
    logic [N-1:0]   wr_data;
    logic [I-1:0]   pred_idx;
    logic [N-1:0]   upd_new;
    logic [N-1:0]   pred_cnt;

    // Only a PC window feeds the index; the remaining bits are don't-care.
    logic           unused_pc;
    assign unused_pc = ^bus.pred_pc;

    // Saturating counter step toward the resolved direction.
    function automatic logic [N-1:0] sat_update(input logic [N-1:0] c, input logic taken);
        if (taken) begin
            return (&c) ? c : c + N'(1);
        end
        return (|c) ? c - N'(1) : c;
    endfunction

    // Shift the resolved outcome into the history; works for M == 1 too.
    function automatic logic [M-1:0] ghr_shift(input logic [M-1:0] g, input logic t);
        logic [M:0] w;
        w = {g, t};
        return w[M-1:0];
    endfunction

    // Table index, counter forwarding and the next-state / output decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ghr_d    = ghr_q;
        ready_d  = ready_q;
        pov_d    = 1'b0;
        taken_d  = taken_q;
        pidx_d   = pidx_q;
        wr_en    = 1'b0;
        wr_addr  = cnt_q;
        wr_data  = WNT;

        if (XOR_HASH != 0) begin
            pred_idx = bus.pred_pc[I+1:2] ^ {{R{1'b0}}, ghr_q};
        end else begin
            pred_idx = {ghr_q, bus.pred_pc[R+1:2]};
        end

        // A same-cycle update to the predicted entry is forwarded (write-first).
        upd_new  = sat_update(table_q[bus.upd_index], bus.upd_taken);
        pred_cnt = (bus.upd_valid && (bus.upd_index == pred_idx)) ? upd_new : table_q[pred_idx];

        if (state_q == INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = WNT;
            cnt_d   = cnt_q + I'(1);
            if (cnt_q == LAST) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end else begin
            if (bus.upd_valid) begin
                wr_en   = 1'b1;
                wr_addr = bus.upd_index;
                wr_data = upd_new;
                ghr_d   = ghr_shift(ghr_q, bus.upd_taken);
            end
            if (bus.pred_valid) begin
                pov_d   = 1'b1;
                taken_d = pred_cnt[N-1];
                pidx_d  = pred_idx;
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ghr_q   <= '0;
            ready_q <= 1'b0;
            pov_q   <= 1'b0;
            taken_q <= 1'b0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ghr_q   <= ghr_d;
            ready_q <= ready_d;
            pov_q   <= pov_d;
            taken_q <= taken_d;
            pidx_q  <= pidx_d;
        end
    end

    // Counter table write port; contents are rebuilt by the sweep after reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    assign bus.ready          = ready_q;
    assign bus.pred_out_valid = pov_q;
    assign bus.pred_taken     = taken_q;
    assign bus.pred_index     = pidx_q;
    assign bus.ghr            = ghr_q;
endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised successor to the correlating (m,n) predictor. It holds a 2^(R+M)-entry table of N-bit saturating counters, indexed by PC bits combined with a global history register (GHR). The index is formed by concatenation (correlating mode) or by XOR (gshare mode). The block has a registered prediction port and an independent update port for resolved branches, and it initialises its own table after reset. It sits between fetch (predict side) and execute/retire (update side).

## Interface
Parameters; table index width I = R+M:
- R, 6, number of PC index bits.
- M, 2, GHR length in bits; legal range is M ≥ 1.
- N, 2, counter width in bits; legal range is N ≥ 2.
- XOR_HASH, 0, index mode: 0 = correlating (concatenate), 1 = gshare (XOR).

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pred_valid  in  1  prediction request this cycle.
- pred_pc  in  32  PC of the branch to predict.
- upd_valid  in  1  resolved-branch update this cycle.
- upd_index  in  I  index returned with the earlier prediction.
- upd_taken  in  1  resolved outcome; 1 = taken.
- ready  out  1  table initialised; requests are accepted only while ready is high.
- pred_out_valid  out  1  pred_taken and pred_index are valid.
- pred_taken  out  1  predicted direction.
- pred_index  out  I  index used; the pipeline carries it to upd_index.
- ghr  out  M  current global history.

## Operation
- Index, correlating mode: {ghr, pred_pc[R+1:2]}.
- Index, gshare mode: pred_pc[I+1:2] ^ {R'b0, ghr}.
- pred_pc[1:0] is ignored in both modes.
- States:
  - INIT: a sweep counter writes WNT = 2^(N-1)-1 to entry cnt each cycle, then increments cnt. For N=2, WNT = 01.
  - INIT → RUN: after entry 2^I-1 is written.
  - RUN: normal operation; stays in RUN until reset.
- In INIT, ready is 0 and pred_valid and upd_valid are ignored. Ignored requests cause no table write, no GHR shift and no pred_out_valid.
- Prediction in RUN, on pred_valid:
  - Compute the index from the current registered ghr.
  - Read the counter and register its MSB as pred_taken.
  - Register the index as pred_index and set pred_out_valid=1 for exactly one cycle.
  - pred_out_valid is 0 in every cycle without an accepted request.
- Update in RUN, on upd_valid:
  - Counter at upd_index saturates: taken → min(c+1, 2^N-1); not taken → max(c-1, 0).
  - GHR shifts: ghr ← {ghr[M-2:0], upd_taken}. For M=1, ghr ← upd_taken.
  - The GHR is non-speculative: only updates shift it.
- Simultaneous predict and update in the same cycle:
  - The prediction index uses the pre-shift ghr.
  - If upd_index equals the prediction index, pred_taken is the MSB of the post-update counter (write-first forwarding).
- Update state is not affected by pred_valid.
- Reset:
  - Reset high forces INIT, cnt=0, ghr=0, ready=0, pred_out_valid=0, pred_taken=0, pred_index=0.
  - Reset mid-INIT or mid-RUN restarts the full sweep. The table contents are then fully rewritten.

## Timing
- Prediction latency is 1 cycle: a request at edge k gives outputs valid after edge k+1.
- One prediction and one update can be accepted per cycle, with no back-pressure.
- An update is visible to a different-index prediction in the next cycle.
- An update is visible to a same-index prediction in the same cycle, through forwarding.
- ready rises exactly 2^I cycles after the first cycle with reset low. The default configuration gives 256 cycles.
- ready is a registered output, and it stays high until reset.

## Test plan
- Reset with defaults, hold reset low: ready=0 for 256 cycles, then 1. Every index then predicts not-taken and the table reads back 01. Reassert reset at cycle 100 of INIT → the 256-cycle count restarts.
- XOR_HASH=0, ghr=0, predict pc=0x0000_0014: pred_index=0x05. Update index 0x05 taken twice: counter goes 01→10→11, the next predict gives taken and ghr=2'b11 via shifts. Predict pc=0x14 again → index 0xC5.
- Saturation, N=3 counter at index 3:
  - Four taken updates give 011→111.
  - A fifth taken update leaves 111.
  - Eight not-taken updates end at 000 and stay there.
- XOR_HASH=1, ghr=2'b10, pc=0x0000_0104 → pred_index = 0x41 ^ 0x02 = 0x43.
- Same-cycle collision: counter at index 7 = 01, upd_valid taken to 7, and a predict mapping to 7 in the same cycle → pred_taken=1. The prediction index uses the old ghr, and ghr shifts the following cycle.
- pred_valid and upd_valid asserted during INIT → no pred_out_valid, ghr stays 0, table unchanged after ready.
